// File: rtl/fc_layer_sequencer.sv
// Layer/group sequencer for the 4-lane FC datapath: per 4-neuron group it clears
// and starts the datapath, streams weight/activation addresses, then writes back.
module fc_layer_sequencer #(
  parameter int unsigned AW = 12
) (
  input  logic          clk,
  input  logic          rst_fsm,
  input  logic          start,
  input  logic [1:0]    num_layers,
  input  logic          cfg_we,
  input  logic [1:0]    cfg_layer,
  input  logic [6:0]    cfg_in_len,
  input  logic [2:0]    cfg_out_grp,
  output logic          fc_start,
  output logic          fc_clr,
  output logic          fc_en,
  output logic [1:0]    fc_layer,
  output logic [AW-1:0] w_addr,
  output logic [7:0]    d_addr,
  output logic          res_we,
  output logic [4:0]    res_addr,
  output logic          busy,
  output logic          done
);

  localparam int unsigned KW = 7;
  localparam int unsigned GW = 3;
  localparam int unsigned LW = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_MAC,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [KW+GW-1:0] cfg_q [4];
  logic [LW-1:0]    layer_q;
  logic [LW-1:0]    num_layers_q;
  logic [GW-1:0]    group_q;
  logic [GW-1:0]    out_grp_q;
  logic [KW-1:0]    k_q;
  logic [KW-1:0]    in_len_q;
  logic [AW-1:0]    w_ptr_q;
  logic [AW-1:0]    w_addr_q;
  logic [7:0]       d_addr_q;
  logic [4:0]       res_addr_q;
  logic             fc_start_q;
  logic             fc_clr_q;
  logic             fc_en_q;
  logic             res_we_q;
  logic             busy_q;
  logic             done_q;

  // Config table has no reset and only accepts writes while idle.
  always_ff @(posedge clk) begin
    if (cfg_we && state_q == S_IDLE) begin
      cfg_q[cfg_layer] <= {cfg_in_len, cfg_out_grp};
    end
  end

  always_ff @(posedge clk or negedge rst_fsm) begin
    if (!rst_fsm) begin
      state_q      <= S_IDLE;
      layer_q      <= '0;
      num_layers_q <= '0;
      group_q      <= '0;
      out_grp_q    <= '0;
      k_q          <= '0;
      in_len_q     <= '0;
      w_ptr_q      <= '0;
      w_addr_q     <= '0;
      d_addr_q     <= '0;
      res_addr_q   <= '0;
      fc_start_q   <= 1'b0;
      fc_clr_q     <= 1'b0;
      fc_en_q      <= 1'b0;
      res_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      fc_start_q <= 1'b0;
      fc_clr_q   <= 1'b0;
      res_we_q   <= 1'b0;
      done_q     <= 1'b0;
      // Beat valid trails the address by the one-cycle RAM read latency.
      fc_en_q    <= (state_q == S_MAC);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q      <= S_CLEAR;
            num_layers_q <= num_layers;
            layer_q      <= '0;
            group_q      <= '0;
            k_q          <= '0;
            w_ptr_q      <= '0;
            fc_start_q   <= 1'b1;
            fc_clr_q     <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        S_CLEAR: begin
          state_q                <= S_MAC;
          {in_len_q, out_grp_q}  <= cfg_q[layer_q];
          k_q                    <= '0;
          w_addr_q               <= w_ptr_q;
          w_ptr_q                <= w_ptr_q + AW'(1);
          d_addr_q               <= {layer_q[0], 7'd0};
        end
        S_MAC: begin
          if (k_q == in_len_q) begin
            state_q <= S_DRAIN;
          end else begin
            k_q      <= k_q + KW'(1);
            w_addr_q <= w_ptr_q;
            w_ptr_q  <= w_ptr_q + AW'(1);
            d_addr_q <= {layer_q[0], k_q + KW'(1)};
          end
        end
        S_DRAIN: begin
          state_q    <= S_WRITE;
          res_we_q   <= 1'b1;
          res_addr_q <= {layer_q, group_q};
        end
        S_WRITE: begin
          if (group_q < out_grp_q) begin
            state_q    <= S_CLEAR;
            group_q    <= group_q + GW'(1);
            fc_start_q <= 1'b1;
            fc_clr_q   <= 1'b1;
          end else if (layer_q < num_layers_q) begin
            state_q    <= S_CLEAR;
            layer_q    <= layer_q + LW'(1);
            group_q    <= '0;
            fc_start_q <= 1'b1;
            fc_clr_q   <= 1'b1;
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fc_start = fc_start_q;
  assign fc_clr   = fc_clr_q;
  assign fc_en    = fc_en_q;
  assign fc_layer = layer_q;
  assign w_addr   = w_addr_q;
  assign d_addr   = d_addr_q;
  assign res_we   = res_we_q;
  assign res_addr = res_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Bench for fc_layer_sequencer: two instances (AW=12 and AW=4) share stimulus and
// are compared cycle by cycle against a schedule built from the layer/group rules.
module tb_fc_layer_sequencer;

  localparam int unsigned AW_A = 12;
  localparam int unsigned AW_B = 4;

  logic            clk = 1'b0;
  logic            rst_fsm;
  logic            start;
  logic [1:0]      num_layers;
  logic            cfg_we;
  logic [1:0]      cfg_layer;
  logic [6:0]      cfg_in_len;
  logic [2:0]      cfg_out_grp;

  logic            fc_start_a, fc_clr_a, fc_en_a, res_we_a, busy_a, done_a;
  logic [1:0]      fc_layer_a;
  logic [AW_A-1:0] w_addr_a;
  logic [7:0]      d_addr_a;
  logic [4:0]      res_addr_a;

  logic            fc_start_b, fc_clr_b, fc_en_b, res_we_b, busy_b, done_b;
  logic [1:0]      fc_layer_b;
  logic [AW_B-1:0] w_addr_b;
  logic [7:0]      d_addr_b;
  logic [4:0]      res_addr_b;

  fc_layer_sequencer #(.AW(AW_A)) u_dut_a (
    .clk(clk), .rst_fsm(rst_fsm), .start(start), .num_layers(num_layers),
    .cfg_we(cfg_we), .cfg_layer(cfg_layer), .cfg_in_len(cfg_in_len), .cfg_out_grp(cfg_out_grp),
    .fc_start(fc_start_a), .fc_clr(fc_clr_a), .fc_en(fc_en_a), .fc_layer(fc_layer_a),
    .w_addr(w_addr_a), .d_addr(d_addr_a), .res_we(res_we_a), .res_addr(res_addr_a),
    .busy(busy_a), .done(done_a)
  );

  fc_layer_sequencer #(.AW(AW_B)) u_dut_b (
    .clk(clk), .rst_fsm(rst_fsm), .start(start), .num_layers(num_layers),
    .cfg_we(cfg_we), .cfg_layer(cfg_layer), .cfg_in_len(cfg_in_len), .cfg_out_grp(cfg_out_grp),
    .fc_start(fc_start_b), .fc_clr(fc_clr_b), .fc_en(fc_en_b), .fc_layer(fc_layer_b),
    .w_addr(w_addr_b), .d_addr(d_addr_b), .res_we(res_we_b), .res_addr(res_addr_b),
    .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          st, clr, en, we, bsy, dn;
    int unsigned layer;
    bit          av;
    int unsigned w, d, ra;
  } exp_t;

  typedef struct {
    int unsigned nl;
    int unsigned len[4];
    int unsigned grp[4];
    int unsigned cyc;
    int unsigned lastw;
  } vec_t;

  exp_t        expq[$];
  vec_t        vt[5];
  int unsigned m_len[4];
  int unsigned m_grp[4];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at time %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(bit st, bit clr, bit en, bit we, bit bsy, bit dn,
                              int unsigned layer, bit av, int unsigned w,
                              int unsigned d, int unsigned ra);
    exp_t e;
    e.st = st; e.clr = clr; e.en = en; e.we = we; e.bsy = bsy; e.dn = dn;
    e.layer = layer; e.av = av; e.w = w; e.d = d; e.ra = ra;
    return e;
  endfunction

  // Expected per-cycle schedule of one run, starting the cycle after start is taken.
  task automatic build(input int unsigned nl);
    int unsigned w = 0;
    expq.delete();
    for (int unsigned l = 0; l <= nl; l++) begin
      for (int unsigned g = 0; g <= m_grp[l]; g++) begin
        expq.push_back(mk(1, 1, 0, 0, 1, 0, l, 0, 0, 0, 0));
        for (int unsigned k = 0; k <= m_len[l]; k++) begin
          expq.push_back(mk(0, 0, k != 0, 0, 1, 0, l, 1, w, (l % 2) * 128 + k, 0));
          w++;
        end
        expq.push_back(mk(0, 0, 1, 0, 1, 0, l, 0, 0, 0, 0));
        expq.push_back(mk(0, 0, 0, 1, 1, 0, l, 0, 0, 0, l * 8 + g));
      end
    end
    expq.push_back(mk(0, 0, 0, 0, 1, 1, nl, 0, 0, 0, 0));
    expq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  function automatic int unsigned en_sum(input int unsigned nl);
    int unsigned s = 0;
    for (int unsigned l = 0; l <= nl; l++) s += (m_grp[l] + 1) * (m_len[l] + 1);
    return s;
  endfunction

  task automatic compare(input exp_t e);
    chk("ctrl_a", {fc_start_a, fc_clr_a, fc_en_a, res_we_a, busy_a, done_a},
        {e.st, e.clr, e.en, e.we, e.bsy, e.dn});
    chk("ctrl_b", {fc_start_b, fc_clr_b, fc_en_b, res_we_b, busy_b, done_b},
        {e.st, e.clr, e.en, e.we, e.bsy, e.dn});
    if (e.bsy) begin
      chk("fc_layer_a", fc_layer_a, e.layer);
      chk("fc_layer_b", fc_layer_b, e.layer);
    end
    if (e.av) begin
      chk("w_addr_a", w_addr_a, e.w % (1 << AW_A));
      chk("w_addr_b", w_addr_b, e.w % (1 << AW_B));
      chk("d_addr_a", d_addr_a, e.d);
      chk("d_addr_b", d_addr_b, e.d);
    end
    if (e.we) begin
      chk("res_addr_a", res_addr_a, e.ra);
      chk("res_addr_b", res_addr_b, e.ra);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_a"}, {fc_start_a, fc_clr_a, fc_en_a, res_we_a, busy_a, done_a,
                       fc_layer_a, d_addr_a, res_addr_a, w_addr_a}, 0);
    chk({name, "_b"}, {fc_start_b, fc_clr_b, fc_en_b, res_we_b, busy_b, done_b,
                       fc_layer_b, d_addr_b, res_addr_b, w_addr_b}, 0);
  endtask

  // Called at a negedge while idle; returns at the negedge after the post-DONE cycle.
  task automatic run(input int unsigned nl, input bit noise,
                     output int unsigned busy_cyc, output int unsigned last_w,
                     output int unsigned en_cyc);
    build(nl);
    start = 1'b1;
    num_layers = 2'(nl);
    @(negedge clk);
    start = 1'b0;
    cfg_we = 1'b0;
    busy_cyc = 0; last_w = 0; en_cyc = 0;
    foreach (expq[i]) begin
      compare(expq[i]);
      if (busy_a === 1'b1) busy_cyc++;
      if (fc_en_a === 1'b1) en_cyc++;
      if (expq[i].av) last_w = 32'(w_addr_a);
      if (noise && i < expq.size() - 1) begin
        start       = ($urandom_range(0, 3) == 0);
        num_layers  = 2'($urandom);
        cfg_we      = ($urandom_range(0, 2) == 0);
        cfg_layer   = 2'($urandom);
        cfg_in_len  = 7'($urandom);
        cfg_out_grp = 3'($urandom);
      end else begin
        start  = 1'b0;
        cfg_we = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic cfg_write(input int unsigned l, input int unsigned len, input int unsigned grp);
    cfg_we = 1'b1;
    cfg_layer = 2'(l);
    cfg_in_len = 7'(len);
    cfg_out_grp = 3'(grp);
    @(negedge clk);
    cfg_we = 1'b0;
    m_len[l] = len;
    m_grp[l] = grp;
  endtask

  task automatic set_vec(input int idx, input int unsigned nl,
                         input int unsigned l0, input int unsigned g0,
                         input int unsigned l1, input int unsigned g1,
                         input int unsigned l2, input int unsigned g2,
                         input int unsigned l3, input int unsigned g3,
                         input int unsigned cyc, input int unsigned lastw);
    vt[idx].nl = nl;
    vt[idx].len[0] = l0; vt[idx].grp[0] = g0;
    vt[idx].len[1] = l1; vt[idx].grp[1] = g1;
    vt[idx].len[2] = l2; vt[idx].grp[2] = g2;
    vt[idx].len[3] = l3; vt[idx].grp[3] = g3;
    vt[idx].cyc = cyc;
    vt[idx].lastw = lastw;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned bc, lw, ec, nl;

    set_vec(0, 0,   3, 0,   0, 0,  0, 0,  0, 0,    8,    3);
    set_vec(1, 2, 127, 7,  15, 1,  3, 0,  0, 0, 1094, 1059);
    set_vec(2, 1,   0, 0,   1, 1,  0, 0,  0, 0,   15,    4);
    set_vec(3, 3,   2, 0,   0, 1,  5, 0,  1, 2,   39,   16);
    set_vec(4, 0,   7, 2,   0, 0,  0, 0,  0, 0,   34,   23);

    rst_fsm = 1'b0; start = 1'b0; num_layers = '0; cfg_we = 1'b0;
    cfg_layer = '0; cfg_in_len = '0; cfg_out_grp = '0;
    #1;
    chk_zero("reset_state");
    repeat (3) @(negedge clk);
    rst_fsm = 1'b1;
    for (int l = 0; l < 4; l++) cfg_write(l, 0, 0);

    // Directed run configurations with hand-computed length and final weight address.
    for (int v = 0; v < 5; v++) begin
      for (int unsigned l = 0; l <= vt[v].nl; l++) cfg_write(l, vt[v].len[l], vt[v].grp[l]);
      run(vt[v].nl, 1'b0, bc, lw, ec);
      chk("run_cycles", bc, vt[v].cyc);
      chk("last_w_addr", lw, vt[v].lastw);
      chk("en_cycles", ec, en_sum(vt[v].nl));
    end

    // start/cfg_we noise while busy, then a clean rerun must see the same entry.
    cfg_write(0, 5, 1);
    run(0, 1'b1, bc, lw, ec);
    chk("noise_run_cycles", bc, 19);
    run(0, 1'b0, bc, lw, ec);
    chk("rerun_cycles", bc, 19);
    chk("rerun_en_cycles", ec, 12);

    // Config write in the same cycle as start takes effect for that run.
    cfg_we = 1'b1; cfg_layer = 2'd0; cfg_in_len = 7'd1; cfg_out_grp = 3'd0;
    m_len[0] = 1; m_grp[0] = 0;
    run(0, 1'b0, bc, lw, ec);
    chk("same_cycle_en", ec, 2);
    chk("same_cycle_cycles", bc, 6);

    // Asynchronous reset in the middle of MAC.
    cfg_write(0, 20, 0);
    start = 1'b1; num_layers = 2'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_fsm = 1'b0;
    #1;
    chk_zero("mid_reset");
    repeat (2) @(negedge clk);
    rst_fsm = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("post_reset_idle", {res_we_a, done_a, busy_a, res_we_b, done_b, busy_b}, 0);
      @(negedge clk);
    end
    cfg_write(0, 3, 1);
    run(0, 1'b0, bc, lw, ec);
    chk("post_reset_cycles", bc, 15);

    // Randomised tables, layer counts and in-run noise.
    for (int r = 0; r < 6; r++) begin
      for (int l = 0; l < 4; l++) cfg_write(l, $urandom_range(0, 127), $urandom_range(0, 7));
      nl = $urandom_range(0, 3);
      run(nl, 1'b1, bc, lw, ec);
      chk("rand_en_cycles", ec, en_sum(nl));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_layer_sequencer.md
# fc_layer_sequencer

Layer/group sequencer for the 4-lane fully connected datapath (`fully_connected_all`). It walks a network of up to 4 FC layers. For each layer it runs every 4-neuron output group through the datapath:

- clears the accumulators and issues the `start` pulse;
- streams kernel/data read addresses to synchronous RAMs;
- qualifies each input beat;
- pulses a result write-back once the last product has been accumulated.

It sits between the top-level run control and the datapath plus its weight, activation and result memories.

## Interface
- `AW`, default 12: weight address width; the running weight pointer wraps modulo 2^AW.
- `clk` in 1: clock; every register updates on the rising edge.
- `rst_fsm` in 1: asynchronous, active-low reset.
- `start` in 1: run request; sampled in IDLE only.
- `num_layers` in 2: layers to run minus 1; sampled when `start` is accepted.
- `cfg_we` in 1: config table write strobe; ignored while `busy`.
- `cfg_layer` in 2: table entry index for the write.
- `cfg_in_len` in 7: input vector length minus 1 (1..128 beats).
- `cfg_out_grp` in 3: output groups minus 1 (1..8 groups of 4 neurons).
- `fc_start` out 1: start pulse to the datapath.
- `fc_clr` out 1: synchronous accumulator clear.
- `fc_en` out 1: current input beat on `i_data`/`i_kernel*` is valid.
- `fc_layer` out 2: layer index driven to the datapath's `layer_fc`.
- `w_addr` out AW: weight RAM read address.
- `d_addr` out 8: activation RAM read address, formatted {bank, k}.
- `res_we` out 1: write strobe that stores the datapath's `o_data1..4`.
- `res_addr` out 5: result address, formatted {layer, group}.
- `busy` out 1: high when the FSM is not in IDLE.
- `done` out 1: one-cycle pulse at the end of a run.

## Operation
- Config table: 4 entries × {in_len[6:0], out_grp[2:0]}, written on `cfg_we` when the FSM is in IDLE. The table has no reset; it is undefined until written.
- State machine: IDLE, CLEAR, MAC, DRAIN, WRITE, DONE.
- IDLE → CLEAR on `start`. Side effects: latch `num_layers`; set layer=0, group=0, k=0, w_ptr=0.
- CLEAR, 1 cycle: `fc_clr`=1, `fc_start`=1, k=0. Next state MAC.
- MAC, in_len+1 cycles:
  - `w_addr`=w_ptr; `d_addr`={layer[0], k}.
  - k and w_ptr each increment by 1 per cycle.
  - Exit to DRAIN after the cycle in which k==in_len.
- DRAIN, 1 cycle: no address is issued. It absorbs the RAM latency so the final `fc_en` beat completes.
- WRITE, 1 cycle: `res_we`=1, `res_addr`={layer, group}. Next state:
  - group < out_grp: group+1, then CLEAR;
  - else layer < num_layers: layer+1, group=0, then CLEAR;
  - else DONE.
- DONE, 1 cycle: `done`=1. Next state IDLE.
- `fc_en` is the MAC-state indicator delayed by one register. The RAM read latency is 1 cycle, so `fc_en` is high exactly in_len+1 cycles: the last MAC cycle plus DRAIN cover the tail.
- Activation ping-pong: layer L reads bank L[0]. Results of layer L are written back by the top level into bank ~L[0]; that write-back is outside this block.
- `fc_layer` = layer register; it is constant for the whole of a layer.
- w_ptr is never reset between groups or layers: weights are packed contiguously in run order.
- The config entry is read by layer index in CLEAR. in_len and out_grp take effect per group and per layer.

## Timing
- Reset values: state=IDLE; `fc_start`, `fc_clr`, `fc_en`, `res_we`, `busy`, `done` = 0; `fc_layer`, `w_addr`, `d_addr`, `res_addr` = 0.
- `start` at edge t → CLEAR during cycle t+1. `busy` rises at t+1 and is high through the DONE cycle.
- Cycles per group = in_len + 4 (CLEAR + MAC(in_len+1) + DRAIN + WRITE).
- Cycles per run = sum over groups of (in_len+4) + 1 (DONE).
- `start` while busy: ignored; it is not queued.
- `cfg_we` and `start` in the same IDLE cycle: the write is committed at that edge and the run uses the new entry.
- `cfg_we` while busy: dropped; the table is unchanged.
- Reset asserted mid-run: all outputs go to reset values immediately. No `res_we` or `done` is emitted, and the next run restarts from w_ptr=0.
- w_ptr wraps from 2^AW−1 to 0 without error.

## Test plan
- Single run with layer0 {in_len=3, out_grp=0}, num_layers=0:
  - CLEAR/`fc_start` pulse, then `w_addr` 0,1,2,3 and `d_addr` 0x00..0x03;
  - `fc_en` high 4 cycles, starting 1 cycle after the first address;
  - `res_we` with `res_addr`=0 at cycle 7 after `start`; `done` at cycle 8.
- 3 layers with {in_len=127, out_grp=7} / {15, 1} / {3, 0}, num_layers=2:
  - layer0 `d_addr` MSB=0, layer1 MSB=1, layer2 MSB=0;
  - `res_addr` sequence 0x00..0x07, 0x08, 0x09, 0x10;
  - final `w_addr` = 1024+32+4−1 = 1059;
  - total 1·(8·131) + 2·19 + 1·7 + 1 = 1094 cycles.
- `start` pulsed mid-run and `cfg_we` writing layer0 while busy → schedule unchanged, and a table read after the run shows the old entry.
- `rst_fsm` low in the middle of MAC → all outputs 0 in the same cycle. A fresh run then starts `w_addr` at 0 and produces no stray `res_we`.
- `cfg_we` and `start` in the same cycle with in_len=1 → MAC lasts 2 cycles in that run.
- AW=4 with layer0 {in_len=7, out_grp=2} → `w_addr` wraps 15→0 during group 2 and the sequence continues.
